uart_bus_master: RTL and testbench

Host-side debug initiator that turns a byte stream from the USB UART into single-word transactions on the picorv32-native memory bus. It is the initiator counterpart to the bus responders (RAM, LED/IO registers, UART data register). It sits between usb_uart's byte interface and a bus arbiter port, and is used for firmware load, peek/poke and core reset over USB. Commands are framed bytes; each command produces exactly one reply sequence.

---
 rtl/uart_bus_master.sv | 177 +++++++++++++++++
 tb/tb_uart_bus_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// UART byte-stream debug initiator: framed W/R/X commands become single-word bus transactions.
// Optional macro BUS_TIMEOUT_EN bounds the bus wait to TIMEOUT_CYCLES and replies NAK on expiry.
module uart_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        core_reset_req
);

    localparam logic [7:0] CmdWrite = 8'h57;
    localparam logic [7:0] CmdRead  = 8'h52;
    localparam logic [7:0] CmdReset = 8'h58;

    typedef enum logic [2:0] {StIdle, StGetAddr, StGetData, StBus, StReply} state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..65535");
    end

    state_t      state;
    logic        is_write;
    logic [1:0]  byte_cnt;
    logic [1:0]  reply_cnt;
    logic [1:0]  reply_last;
    logic [1:0]  reply_nxt;
    logic [31:0] rdata_q;
    logic [7:0]  addr_byte;
    logic        in_fire;
    logic        last_byte;

    assign in_fire   = in_valid && in_ready;
    assign last_byte = (byte_cnt == 2'd3);
    assign reply_nxt = reply_cnt + 2'd1;
    // Word addressing: the two low address bits are dropped as the first byte arrives.
    assign addr_byte = (byte_cnt == 2'd0) ? {in_data[7:2], 2'b00} : in_data;

`ifdef BUS_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tmo_hit;
    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= StIdle;
            in_ready       <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= 8'h00;
            mem_valid      <= 1'b0;
            mem_addr       <= 32'h0;
            mem_wdata      <= 32'h0;
            mem_wstrb      <= 4'h0;
            core_reset_req <= 1'b0;
            is_write       <= 1'b0;
            byte_cnt       <= 2'd0;
            reply_cnt      <= 2'd0;
            reply_last     <= 2'd0;
            rdata_q        <= 32'h0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt        <= 16'd0;
`endif
        end else begin
            core_reset_req <= 1'b0;
            unique case (state)
                StIdle: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        byte_cnt <= 2'd0;
                        if (in_data == CmdWrite || in_data == CmdRead) begin
                            is_write <= (in_data == CmdWrite);
                            state    <= StGetAddr;
                        end else begin
                            in_ready       <= 1'b0;
                            out_valid      <= 1'b1;
                            reply_cnt      <= 2'd0;
                            reply_last     <= 2'd0;
                            core_reset_req <= (in_data == CmdReset);
                            out_data       <= (in_data == CmdReset) ? ACK_BYTE : NAK_BYTE;
                            state          <= StReply;
                        end
                    end
                end
                StGetAddr: begin
                    if (in_fire) begin
                        mem_addr[{byte_cnt, 3'b000} +: 8] <= addr_byte;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            if (is_write) begin
                                state <= StGetData;
                            end else begin
                                in_ready  <= 1'b0;
                                mem_valid <= 1'b1;
                                mem_wstrb <= 4'h0;
                                state     <= StBus;
`ifdef BUS_TIMEOUT_EN
                                tmo_cnt   <= 16'd0;
`endif
                            end
                        end
                    end
                end
                StGetData: begin
                    if (in_fire) begin
                        mem_wdata[{byte_cnt, 3'b000} +: 8] <= in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            in_ready  <= 1'b0;
                            mem_valid <= 1'b1;
                            mem_wstrb <= 4'hF;
                            state     <= StBus;
`ifdef BUS_TIMEOUT_EN
                            tmo_cnt   <= 16'd0;
`endif
                        end
                    end
                end
                StBus: begin
                    // A response on the timeout edge still completes the transaction.
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        out_valid <= 1'b1;
                        reply_cnt <= 2'd0;
                        state     <= StReply;
                        if (is_write) begin
                            out_data   <= ACK_BYTE;
                            reply_last <= 2'd0;
                        end else begin
                            rdata_q    <= mem_rdata;
                            out_data   <= mem_rdata[7:0];
                            reply_last <= 2'd3;
                        end
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tmo_hit) begin
                        mem_valid  <= 1'b0;
                        out_valid  <= 1'b1;
                        out_data   <= NAK_BYTE;
                        reply_cnt  <= 2'd0;
                        reply_last <= 2'd0;
                        state      <= StReply;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                StReply: begin
                    if (out_valid && out_ready) begin
                        if (reply_cnt == reply_last) begin
                            out_valid <= 1'b0;
                            state     <= StIdle;
                        end else begin
                            reply_cnt <= reply_nxt;
                            out_data  <= rdata_q[{reply_nxt, 3'b000} +: 8];
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: directed scenarios plus randomized W/R traffic
// against a word-addressed memory model.
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        core_reset_req;

    int n_checks = 0;
    int n_fail   = 0;
    bit no_bus_ok;
    logic [31:0] mem_model [logic [31:0]];

    always #5 clk = ~clk;

    uart_bus_master #(
        .TIMEOUT_CYCLES(16),
        .ACK_BYTE      (8'h06),
        .NAK_BYTE      (8'h15)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .core_reset_req(core_reset_req)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at a negedge; inputs change there, outputs are sampled there.
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready === 1'b1) done = 1'b1;
            if (mem_valid !== 1'b0) no_bus_ok = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                            input bit with_data);
        send_byte(c);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        if (with_data) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic serve(input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                         input logic [3:0] exp_wstrb, input logic [31:0] rdata, input int delay);
        bit hold_ok;
        chk("mem_valid_latency", {31'b0, mem_valid}, 32'd1);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, exp_wstrb});
        if (exp_wstrb == 4'hF) chk("mem_wdata", mem_wdata, exp_wdata);
        hold_ok = (in_ready === 1'b0);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (mem_valid !== 1'b1 || mem_addr !== exp_addr || mem_wstrb !== exp_wstrb ||
                in_ready !== 1'b0 || out_valid !== 1'b0) hold_ok = 1'b0;
        end
        chk("bus_hold", {31'b0, hold_ok}, 32'd1);
        mem_ready = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        chk("mem_valid_drop", {31'b0, mem_valid}, 32'd0);
        chk("reply_start", {31'b0, out_valid}, 32'd1);
    endtask

    // mode 0: random out_ready; mode 1: out_ready alternates 0/1.
    task automatic recv(input logic [31:0] exp_word, input int n, input int mode);
        bit         tog;
        bit         got;
        bit         seen;
        bit         held_ok;
        logic [7:0] held;
        tog = 1'b0;
        for (int k = 0; k < n; k++) begin
            got     = 1'b0;
            seen    = 1'b0;
            held_ok = 1'b1;
            held    = 8'hxx;
            for (int t = 0; t < 40 && !got; t++) begin
                if (mode == 1) begin
                    out_ready = tog;
                    tog       = ~tog;
                end else begin
                    out_ready = 1'($urandom_range(0, 1));
                end
                if (out_valid === 1'b1) begin
                    if (seen && out_data !== held) held_ok = 1'b0;
                    held = out_data;
                    seen = 1'b1;
                    if (out_ready) got = 1'b1;
                end
                if (in_ready !== 1'b0) held_ok = 1'b0;
                if (mem_valid !== 1'b0) no_bus_ok = 1'b0;
                @(negedge clk);
            end
            out_ready = 1'b0;
            chk($sformatf("reply_byte%0d", k), {24'b0, held}, {24'b0, exp_word[8*k +: 8]});
            chk($sformatf("reply_stable%0d", k), {31'b0, held_ok}, 32'd1);
        end
        chk("reply_end", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int delay,
                            input int mode);
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        send_cmd(8'h57, a, d, 1'b1);
        serve(wa, d, 4'hF, $urandom, delay);
        mem_model[wa] = d;
        recv(32'h06, 1, mode);
    endtask

    task automatic do_read(input logic [31:0] a, input int delay, input int mode,
                           input bit hold_in);
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        if (!mem_model.exists(wa)) mem_model[wa] = $urandom;
        send_cmd(8'h52, a, 32'h0, 1'b0);
        if (hold_in) begin
            in_valid = 1'b1;
            in_data  = 8'h41;
        end
        serve(wa, 32'h0, 4'h0, mem_model[wa], delay);
        recv(mem_model[wa], 4, mode);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        no_bus_ok = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_data", {24'b0, out_data}, 32'd0);
        chk("reset_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        chk("reset_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
        chk("reset_core_rst", {31'b0, core_reset_req}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

        // Write 0xDEADBEEF to 0x1000, responder ready after 3 cycles.
        do_write(32'h0000_1000, 32'hDEAD_BEEF, 3, 0);

        // Read 0x02000008 returning 0x12345678, out_ready toggling.
        mem_model[32'h0200_0008] = 32'h1234_5678;
        do_read(32'h0200_0008, 2, 1, 1'b0);

        // Unknown command with a stray mem_ready, then core reset.
        no_bus_ok = 1'b1;
        mem_ready = 1'b1;
        send_byte(8'h41);
        recv(32'h15, 1, 0);
        mem_ready = 1'b0;
        chk("nak_no_bus", {31'b0, no_bus_ok}, 32'd1);
        send_byte(8'h58);
        chk("core_rst_pulse", {31'b0, core_reset_req}, 32'd1);
        chk("core_rst_reply", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        chk("core_rst_one_cycle", {31'b0, core_reset_req}, 32'd0);
        recv(32'h06, 1, 0);

        // Low address bits masked; a byte held during BUS/REPLY is only taken afterwards.
        do_read(32'h0000_0003, 4, 0, 1'b1);
        send_byte(8'h41);
        recv(32'h15, 1, 0);

        // Reset during GET_DATA, then during BUS.
        send_byte(8'h57);
        for (int i = 0; i < 4; i++) send_byte(8'h20);
        send_byte(8'hAA);
        send_byte(8'hBB);
        pulse_reset();
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        send_cmd(8'h52, 32'h0000_0044, 32'h0, 1'b0);
        chk("bus_before_rst", {31'b0, mem_valid}, 32'd1);
        pulse_reset();
        do_read(32'h0000_0040, 1, 0, 1'b0);

        // Randomized traffic over a small address window so reads revisit written words.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom, $urandom_range(0, 4), 0);
            else do_read(a, $urandom_range(0, 4), 0, 1'b0);
        end

`ifdef BUS_TIMEOUT_EN
        // Responder never ready: 16 cycles of mem_valid, then NAK.
        send_cmd(8'h52, 32'h0000_0100, 32'h0, 1'b0);
        n = 0;
        while (mem_valid === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_cycles", n, 32'd16);
        chk("timeout_reply", {31'b0, out_valid}, 32'd1);
        recv(32'h15, 1, 0);
        // mem_ready on the timeout edge completes normally.
        send_cmd(8'h52, 32'h0000_0104, 32'h0, 1'b0);
        for (int i = 1; i < 16; i++) @(negedge clk);
        chk("timeout_edge_valid", {31'b0, mem_valid}, 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_ready = 1'b0;
        recv(32'hCAFE_F00D, 4, 0);
`else
        // Without a timeout the request waits indefinitely.
        send_cmd(8'h52, 32'h0000_0100, 32'h0, 1'b0);
        n = 1;
        repeat (999) @(negedge clk);
        chk("no_timeout_cycle1000", {31'b0, mem_valid}, 32'd1);
        pulse_reset();
`endif
        do_read(32'h0000_1000, 0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
